// File: rtl/mproc_seq.sv
// mproc_seq: multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit teaching processor.
// Define MPROC_SEQ_TIMEOUT_EN to add the fetch watchdog and the FAULT state.
module mproc_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [15:0] cur_ins,
    output logic        mem_req,
    output logic        load_ir,
    output logic        pc_inc,
    output logic        jump,
    output logic        wr_reg,
    output logic        sel,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic        halted,
    output logic        fault,
    output logic [7:0]  retired
);

    localparam int unsigned RET_W = 8;

`ifdef MPROC_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;
`endif

    state_t state;
    state_t state_n;
    logic   retire;
    logic   is_alu;
    logic   is_jump;
    logic   unused_ins_bits;

    // Field extracts are valid whenever the IR holds a decoded instruction.
    assign is_alu          = ~cur_ins[15];
    assign is_jump         = (cur_ins[15:14] == 2'b10);
    assign op              = cur_ins[14:13];
    assign wr_addr         = cur_ins[12:10];
    assign rd_addr_a       = cur_ins[9:7];
    assign rd_addr_b       = cur_ins[6:4];
    assign sel             = cur_ins[3];
    assign unused_ins_bits = ^cur_ins[2:0];

`ifdef MPROC_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = 4;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    // Counts consecutive un-acked FETCH cycles; zero whenever not waiting in FETCH.
    always_ff @(posedge clk) begin
        if (reset || (state != S_FETCH) || mem_ack) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_expire = (wd_cnt == {WD_W{1'b1}});
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + RET_W'(1);
        end
    end

    // Next-state and strobe decode; load_ir is the only output that looks at mem_ack.
    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        load_ir = 1'b0;
        pc_inc  = 1'b0;
        jump    = 1'b0;
        wr_reg  = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        retire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    state_n = S_DECODE;
                end
`ifdef MPROC_SEQ_TIMEOUT_EN
                else if (wd_expire) begin
                    state_n = S_FAULT;
                end
`endif
            end
            S_DECODE: begin
                if (is_alu) begin
                    pc_inc  = 1'b1;
                    state_n = S_EXEC;
                end else if (is_jump) begin
                    jump    = 1'b1;
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_HALT;
                end
            end
            S_EXEC: begin
                state_n = S_WB;
            end
            S_WB: begin
                wr_reg  = 1'b1;
                retire  = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef MPROC_SEQ_TIMEOUT_EN
            S_FAULT: begin
                fault = 1'b1;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mproc_seq.sv
// Testbench for mproc_seq: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a per-instruction cycle-schedule model.
module tb_mproc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_ack;
    logic [15:0] cur_ins;
    logic        mem_req, load_ir, pc_inc, jump, wr_reg, sel;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic        halted, fault;
    logic [7:0]  retired;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe vector bit positions: {mem_req, load_ir, pc_inc, jump, wr_reg, halted, fault}
    localparam logic [6:0] REQ = 7'b1000000;
    localparam logic [6:0] LIR = 7'b0100000;
    localparam logic [6:0] INC = 7'b0010000;
    localparam logic [6:0] JMP = 7'b0001000;
    localparam logic [6:0] WB  = 7'b0000100;
    localparam logic [6:0] HLT = 7'b0000010;
    localparam logic [6:0] FLT = 7'b0000001;
    localparam logic [6:0] NON = 7'b0000000;

    // Schedule entries for the cycles that follow an acknowledged fetch
    localparam int P_INC  = 0;
    localparam int P_NONE = 1;
    localparam int P_WB   = 2;
    localparam int P_JMP  = 3;
    localparam int P_HDEC = 4;

    mproc_seq dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_ack   (mem_ack),
        .cur_ins   (cur_ins),
        .mem_req   (mem_req),
        .load_ir   (load_ir),
        .pc_inc    (pc_inc),
        .jump      (jump),
        .wr_reg    (wr_reg),
        .sel       (sel),
        .op        (op),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic        ack;
        logic [15:0] ins;
        logic [6:0]  es;
        int          eret;
        logic [11:0] edec;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [6:0] strobes();
        return {mem_req, load_ir, pc_inc, jump, wr_reg, halted, fault};
    endfunction

    function automatic logic [11:0] dec_act();
        return {op, wr_addr, rd_addr_a, rd_addr_b, sel};
    endfunction

    // Field layout computed arithmetically: op=[14:13] wr=[12:10] a=[9:7] b=[6:4] sel=[3]
    function automatic logic [11:0] dec_exp(input logic [15:0] ins);
        int v;
        logic [11:0] r;
        v = int'(ins);
        r[11:10] = 2'((v / 8192) % 4);
        r[9:7]   = 3'((v / 1024) % 8);
        r[6:4]   = 3'((v / 128) % 8);
        r[3:1]   = 3'((v / 16) % 8);
        r[0]     = 1'((v / 8) % 2);
        return r;
    endfunction

    task automatic cyc(input logic r, input logic ru, input logic a, input logic [15:0] ins);
        @(negedge clk);
        reset   = r;
        run     = ru;
        mem_ack = a;
        cur_ins = ins;
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] es, input int eret);
        n_tests++;
        if (strobes() !== es || retired !== 8'(eret)) begin
            n_fail++;
            $display("FAIL %s: strobes=%b retired=%0d, required strobes=%b retired=%0d",
                     name, strobes(), retired, es, eret);
        end
    endtask

    task automatic chk_dec(input string name, input logic [11:0] edec);
        n_tests++;
        if (dec_act() !== edec) begin
            n_fail++;
            $display("FAIL %s: decode=%h, required decode=%h (ins=%h)",
                     name, dec_act(), edec, cur_ins);
        end
    endtask

    // Reference model state
    int          m_mode;   // 0 idle, 1 running, 2 halted, 3 faulted
    int          m_ret;
    int          m_nack;
    int          plan[$];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        r, ru, a;
        logic [15:0] ins;
        logic [6:0]  es;
        int          ret_now;
        int          cls;
        int          e;

        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; cur_ins = 16'h0000;
        @(posedge clk);

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, NON,       0, 12'h000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0A90, NON,       0, 12'h152};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0A90, REQ | LIR, 0, 12'h152};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0A90, INC,       0, 12'h152};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0A90, NON,       0, 12'h152};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0A90, WB,        0, 12'h152};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h8005, REQ | LIR, 1, 12'h000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h8005, JMP,       1, 12'h000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'hC000, REQ | LIR, 2, 12'h800};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'hC000, NON,       2, 12'h800};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'hC000, HLT,       2, 12'h800};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 16'hC000, HLT,       2, 12'h800};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].run, tbl[i].ack, tbl[i].ins);
            chk($sformatf("vec%0d", i), tbl[i].es, tbl[i].eret);
            chk_dec($sformatf("vec%0d_dec", i), tbl[i].edec);
        end

        // HALT holds despite run, then reset returns to IDLE
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'hC000);
            chk("halt_hold", HLT, 2);
        end
        cyc(1'b1, 1'b1, 1'b0, 16'hC000);
        chk("halt_reset_cycle", HLT, 2);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("idle_after_halt_reset", NON, 0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("idle_stays", NON, 0);

        // Five cycles without ack, then ack; reset lands in EXEC
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("idle_run", NON, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0A90);
            chk("fetch_wait", REQ, 0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0A90);
        chk("fetch_ack", REQ | LIR, 0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0A90);
        chk("decode_alu", INC, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0A90);
        chk("exec_reset_cycle", NON, 0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0A90);
        chk("idle_after_exec_reset", NON, 0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0A90);
        chk("no_wr_after_exec_reset", NON, 0);

        // Long ack starvation: fault with the watchdog, indefinite wait without it
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("idle_run2", NON, 0);
`ifdef MPROC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("wd_wait", REQ, 0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h8005);
        chk("wd_fault", FLT, 0);
        cyc(1'b0, 1'b1, 1'b1, 16'h8005);
        chk("wd_fault_hold", FLT, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("wd_fault_reset_cycle", FLT, 0);
`else
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("long_wait", REQ, 0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h8005);
        chk("long_wait_ack", REQ | LIR, 0);
        cyc(1'b0, 1'b0, 1'b0, 16'h8005);
        chk("long_wait_jump", JMP, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("long_wait_reset_cycle", REQ, 1);
`endif
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("idle_after_wait_reset", NON, 0);

        // 256 back-to-back jumps wrap the retired counter
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("wrap_start", NON, 0);
        for (int k = 0; k < 256; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 16'h8005);
            chk("wrap_fetch", REQ | LIR, k);
            cyc(1'b0, 1'b0, 1'b0, 16'h8005);
            chk("wrap_jump", JMP, k);
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h8005);
        chk("wrap_zero", REQ, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("wrap_reset_cycle", REQ, 0);

        // Randomized traffic against the schedule model
        m_mode = 0; m_ret = 0; m_nack = 0; plan.delete();
        ins = 16'h0000;
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 59) == 0) || (m_mode >= 2 && $urandom_range(0, 3) == 0);
            ru = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 2) != 0);
            if (plan.size() == 0) begin
                cls = int'($urandom_range(0, 9));
                if (cls < 6)      ins = {1'b0, 15'($urandom)};
                else if (cls < 9) ins = {2'b10, 14'($urandom)};
                else              ins = {2'b11, 14'($urandom)};
            end
            cyc(r, ru, a, ins);

            es = NON;
            ret_now = m_ret;
            case (m_mode)
                0: begin
                    m_nack = 0;
                    if (ru) m_mode = 1;
                end
                1: begin
                    if (plan.size() == 0) begin
                        es = a ? (REQ | LIR) : REQ;
                        if (a) begin
                            m_nack = 0;
                            if (!ins[15]) begin
                                plan.push_back(P_INC);
                                plan.push_back(P_NONE);
                                plan.push_back(P_WB);
                            end else if (!ins[14]) begin
                                plan.push_back(P_JMP);
                            end else begin
                                plan.push_back(P_HDEC);
                            end
                        end else begin
                            m_nack++;
`ifdef MPROC_SEQ_TIMEOUT_EN
                            if (m_nack == 16) m_mode = 3;
`endif
                        end
                    end else begin
                        m_nack = 0;
                        e = plan.pop_front();
                        case (e)
                            P_INC:  es = INC;
                            P_WB:   begin es = WB;  m_ret = (m_ret + 1) % 256; end
                            P_JMP:  begin es = JMP; m_ret = (m_ret + 1) % 256; end
                            P_HDEC: m_mode = 2;
                            default: es = NON;
                        endcase
                    end
                end
                2: es = HLT;
                default: es = FLT;
            endcase

            chk("rand", es, ret_now);
            chk_dec("rand_dec", dec_exp(cur_ins));

            if (r) begin
                m_mode = 0; m_ret = 0; m_nack = 0; plan.delete();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
